// File: rtl/int_div_if.sv
// ============================================================================
// Module      : int_div_if
// Description : Start/done handshake bundle for the sequential divider.
//               Optional dz flag present when DIV_ZERO_FLAG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface int_div_if #(
    parameter int WIDTH_DIVIDEND = 13,
    parameter int WIDTH_DIVISOR  = 4
);
    localparam int c_QW = WIDTH_DIVIDEND - WIDTH_DIVISOR + 1;

    logic                      start;
    logic [WIDTH_DIVIDEND-1:0] a;
    logic [WIDTH_DIVISOR-1:0]  b;
    logic                      busy;
    logic                      done;
    logic [c_QW-1:0]           res;
    logic [WIDTH_DIVISOR-1:0]  mod;
    logic                      ovf;
`ifdef DIV_ZERO_FLAG_EN
    logic                      dz;

    modport master (output start, a, b, input busy, done, res, mod, ovf, dz);
    modport slave  (input start, a, b, output busy, done, res, mod, ovf, dz);
`else
    modport master (output start, a, b, input busy, done, res, mod, ovf);
    modport slave  (input start, a, b, output busy, done, res, mod, ovf);
`endif
endinterface

`default_nettype wire

// File: rtl/int_div.sv
// ============================================================================
// Module      : int_div
// Description : Restoring shift-subtract unsigned divider, one quotient bit
//               per clock. DIV_ZERO_FLAG_EN adds the dz divide-by-zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module int_div #(
    parameter int WIDTH_DIVIDEND = 13,
    parameter int WIDTH_DIVISOR  = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    int_div_if.slave  bus
);
    localparam int c_QW = WIDTH_DIVIDEND - WIDTH_DIVISOR + 1;
    localparam int c_CW = $clog2(c_QW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [c_CW-1:0]            r_cnt;
    logic [c_QW-1:0]            r_work;
    logic [WIDTH_DIVISOR-1:0]   r_rem;
    logic [WIDTH_DIVISOR-1:0]   r_b;
    logic                       r_ovf_pend;
    logic                       r_busy;
    logic                       r_done;
    logic [c_QW-1:0]            r_res;
    logic [WIDTH_DIVISOR-1:0]   r_mod;
    logic                       r_ovf;

    logic                       w_ovf_req;
    logic [WIDTH_DIVISOR-1:0]   w_a_top;
    logic [WIDTH_DIVISOR:0]     w_shift;
    logic                       w_ge;
    logic [WIDTH_DIVISOR-1:0]   w_rem_next;

    // Quotient fits in c_QW bits only if the top dividend bits are below b.
    assign w_ovf_req  = (bus.a >> c_QW) >= WIDTH_DIVIDEND'(bus.b);
    assign w_a_top    = WIDTH_DIVISOR'(bus.a >> c_QW);
    assign w_shift    = {r_rem, r_work[c_QW-1]};
    assign w_ge       = w_shift >= {1'b0, r_b};
    // The true difference is below b, so the low bits of the subtraction suffice.
    assign w_rem_next = w_ge ? (w_shift[WIDTH_DIVISOR-1:0] - r_b) : w_shift[WIDTH_DIVISOR-1:0];

`ifdef DIV_ZERO_FLAG_EN
    logic r_dz_pend;
    logic r_dz;
    assign bus.dz = r_dz;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_work     <= '0;
            r_rem      <= '0;
            r_b        <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_res      <= '0;
            r_mod      <= '0;
            r_ovf      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            r_dz_pend  <= 1'b0;
            r_dz       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_CALC;
                        r_busy     <= 1'b1;
                        r_b        <= bus.b;
                        r_ovf_pend <= w_ovf_req;
`ifdef DIV_ZERO_FLAG_EN
                        r_dz_pend  <= (bus.b == '0);
                        r_dz       <= 1'b0;
`endif
                        if (w_ovf_req) begin
                            // Preload the saturated result; a zero count finishes next edge.
                            r_cnt  <= '0;
                            r_work <= '1;
                            r_rem  <= bus.a[WIDTH_DIVISOR-1:0];
                        end else begin
                            r_cnt  <= c_CW'(c_QW);
                            r_work <= bus.a[c_QW-1:0];
                            r_rem  <= w_a_top;
                        end
                    end
                end
                S_CALC: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_res   <= r_work;
                        r_mod   <= r_rem;
                        r_ovf   <= r_ovf_pend;
`ifdef DIV_ZERO_FLAG_EN
                        r_dz    <= r_dz_pend;
`endif
                    end else begin
                        // Dividend bits leave at the top while quotient bits enter at the bottom.
                        r_cnt  <= r_cnt - c_CW'(1);
                        r_work <= (r_work << 1) | c_QW'(w_ge);
                        r_rem  <= w_rem_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.res  = r_res;
    assign bus.mod  = r_mod;
    assign bus.ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_int_div.sv
// ============================================================================
// Module      : tb_int_div
// Description : Self-checking bench for int_div (WD=13, WS=4, QW=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_int_div;
    localparam int WD = 13;
    localparam int WS = 4;
    localparam int QW = WD - WS + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int_div_if #(.WIDTH_DIVIDEND(WD), .WIDTH_DIVISOR(WS)) bus ();
    int_div #(.WIDTH_DIVIDEND(WD), .WIDTH_DIVISOR(WS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int res;
        int mod;
        int ovf;
        int dz;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    int   n_acc    = 0;

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if ((a / (1 << QW)) >= b) begin
            e.res = (1 << QW) - 1;
            e.mod = a % (1 << WS);
            e.ovf = 1;
`ifdef DIV_ZERO_FLAG_EN
            e.dz  = (b == 0) ? 1 : 0;
`else
            e.dz  = 0;
`endif
        end else begin
            e.res = a / b;
            e.mod = a % b;
            e.ovf = 0;
            e.dz  = 0;
        end
        return e;
    endfunction

    function automatic logic get_dz();
`ifdef DIV_ZERO_FLAG_EN
        return bus.dz;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Result checker: every done pulse must match the oldest accepted request.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got 1 expected 0");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res", 32'(bus.res), e.res);
                chk("mod", 32'(bus.mod), e.mod);
                chk("ovf", 32'(bus.ovf), e.ovf);
                chk("dz", 32'(get_dz()), e.dz);
                chk("busy_at_done", 32'(bus.busy), 0);
            end
        end
    end

    task automatic launch(input int a, input int b);
        int g;
        g = 0;
        @(negedge clk);
        while ((bus.busy || bus.done) && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) chk("idle_wait", 0, 1);
        bus.a     = WD'(a);
        bus.b     = WS'(b);
        bus.start = 1'b1;
        q.push_back(model(a, b));
        n_acc++;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = WD'($urandom);
        bus.b     = WS'($urandom);
        chk("busy_after_start", 32'(bus.busy), 1);
    endtask

    task automatic wait_done(input int exp_lat);
        int lat;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic do_op(input int a, input int b);
        exp_t e;
        e = model(a, b);
        launch(a, b);
        wait_done(e.ovf != 0 ? 1 : QW + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_mod", 32'(bus.mod), 0);
        chk("rst_ovf", 32'(bus.ovf), 0);
        chk("rst_dz", 32'(get_dz()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4500, 10);
        @(negedge clk);
        chk("pin_4500_10_res", 32'(bus.res), 450);
        chk("pin_4500_10_mod", 32'(bus.mod), 0);

        do_op(4500, 13);
        @(negedge clk);
        chk("pin_4500_13_res", 32'(bus.res), 346);
        chk("pin_4500_13_mod", 32'(bus.mod), 2);

        do_op(8191, 15);
        @(negedge clk);
        chk("pin_8191_15_res", 32'(bus.res), 546);
        chk("pin_8191_15_mod", 32'(bus.mod), 1);

        do_op(8191, 1);
        @(negedge clk);
        chk("pin_8191_1_res", 32'(bus.res), 1023);
        chk("pin_8191_1_mod", 32'(bus.mod), 15);
        chk("pin_8191_1_ovf", 32'(bus.ovf), 1);

        do_op(8191, 7);
        do_op(1234, 0);
        @(negedge clk);
        chk("pin_b0_ovf", 32'(bus.ovf), 1);
        chk("pin_b0_mod", 32'(bus.mod), 2);

        // Start asserted only in the DONE cycle must be dropped.
        do_op(6000, 8);
        bus.start = 1'b1;
        bus.a     = WD'(100);
        bus.b     = WS'(9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("done_cycle_start_ignored", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("still_idle", 32'(bus.busy), 0);
        chk("pin_6000_8_res", 32'(bus.res), 750);
        chk("pin_6000_8_ovf", 32'(bus.ovf), 0);
        chk("pin_6000_8_dz", 32'(get_dz()), 0);

        // Starts while busy are ignored.
        launch(5000, 9);
        repeat (3) begin
            bus.start = 1'b1;
            bus.a     = WD'(8191);
            bus.b     = WS'(1);
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_done(QW + 1 - 3);
        @(negedge clk);
        chk("pin_5000_9_res", 32'(bus.res), 555);
        chk("pin_5000_9_mod", 32'(bus.mod), 5);

        // Asynchronous reset in the middle of a calculation.
        launch(7000, 11);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_done", 32'(bus.done), 0);
        chk("midrst_res", 32'(bus.res), 0);
        chk("midrst_mod", 32'(bus.mod), 0);
        chk("midrst_ovf", 32'(bus.ovf), 0);
        chk("midrst_dz", 32'(get_dz()), 0);
        q.delete();
        n_acc--;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(bus.busy), 0);

        do_op(3000, 12);
        @(negedge clk);
        chk("pin_3000_12_res", 32'(bus.res), 250);

        for (int i = 0; i < 500; i++) begin
            int ra;
            int rb;
            ra = 4096 + int'($urandom_range(4095, 0));
            rb = 8 + int'($urandom_range(7, 0));
            do_op(ra, rb);
        end

        repeat (5) @(negedge clk);
        chk("done_count", n_done, n_acc);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
